// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, CTRL fields and FSM encoding for timer_dev
package timer_pkg;

  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] PRESET_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;

  localparam int EN_BIT  = 0;
  localparam int MODE_LO = 1;
  localparam int MODE_HI = 2;
  localparam int IM_BIT  = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    INT  = 2'd2
  } state_t;

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with one-shot/auto-reload modes and maskable irq
module timer_dev
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  state_t      state, state_nxt;
  logic        en, en_nxt;
  logic        im, im_nxt;
  logic [1:0]  mode, mode_nxt;
  logic [31:0] preset, preset_nxt;
  logic [31:0] count, count_nxt;
  logic        pending, pending_nxt;
  logic        wr_ctrl, wr_preset;
  logic [3:0]  ctrl_val;

  assign wr_ctrl   = we && (addr == CTRL_OFF);
  assign wr_preset = we && (addr == PRESET_OFF);
  assign irq       = pending & im;

  always_comb begin
    state_nxt   = state;
    en_nxt      = en;
    im_nxt      = im;
    mode_nxt    = mode;
    preset_nxt  = preset;
    count_nxt   = count;
    pending_nxt = pending;

    case (state)
      IDLE: begin
        if (en) begin
          count_nxt = preset;
          state_nxt = CNT;
        end
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt   = '0;
          pending_nxt = 1'b1;
          state_nxt   = INT;
        end
      end
      INT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (mode == MODE_RELOAD) begin
          count_nxt   = preset;
          pending_nxt = 1'b0;
          state_nxt   = CNT;
        end else begin
          en_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Software writes are applied last so they override FSM updates of en and pending.
    if (wr_ctrl) begin
      en_nxt      = din[EN_BIT];
      mode_nxt    = din[MODE_HI:MODE_LO];
      im_nxt      = din[IM_BIT];
      pending_nxt = 1'b0;
    end
    if (wr_preset) begin
      preset_nxt  = din;
      pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      en      <= 1'b0;
      im      <= 1'b0;
      mode    <= MODE_ONESHOT;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      en      <= en_nxt;
      im      <= im_nxt;
      mode    <= mode_nxt;
      preset  <= preset_nxt;
      count   <= count_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    ctrl_val                  = '0;
    ctrl_val[EN_BIT]          = en;
    ctrl_val[MODE_HI:MODE_LO] = mode;
    ctrl_val[IM_BIT]          = im;
    case (addr)
      CTRL_OFF:   dout = {28'd0, ctrl_val};
      PRESET_OFF: dout = preset;
      COUNT_OFF:  dout = count;
      default:    dout = '0;
    endcase
  end

endmodule
